// File: rtl/ringbuf_wr_ctrl_pkg.sv
// Shared constants, FSM state type and slot-geometry helpers for the ring-buffer
// write controller and its interface.
package ringbuf_pkg;

    localparam int SAMPLE_W = 12;
    localparam int N_CHAN   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } wr_state_e;

    // One event holds every channel's samples back to back.
    function automatic int evt_words(input int samples);
        return N_CHAN * samples;
    endfunction

    function automatic int nslots(input int addr_w, input int samples);
        return (1 << addr_w) / evt_words(samples);
    endfunction

endpackage

// File: rtl/ringbuf_wr_ctrl_if.sv
// Handshake and status bundle between the sample transfer stage / readout and
// the ring-buffer write controller.
interface ringbuf_wr_ctrl_if #(
    parameter int ADDR_W  = 11,
    parameter int SAMPLES = 8
);
    localparam int NSLOTS = ringbuf_pkg::nslots(ADDR_W, SAMPLES);
    localparam int NOCC_W = $clog2(NSLOTS) + 1;

    logic                          wren;
    logic [ringbuf_pkg::SAMPLE_W-1:0] din;
    logic                          evt_ack;
    logic                          rd_done;

    logic                          rb_we;
    logic [ADDR_W-1:0]             rb_waddr;
    logic [ringbuf_pkg::SAMPLE_W-1:0] rb_wdata;
    logic                          evt_avail;
    logic [ADDR_W-1:0]             evt_base;
    logic                          full;
    logic [NOCC_W-1:0]             n_occ;
    logic [7:0]                    ovfl_cnt;
    logic                          seq_err;

    // Master drives samples and readout handshakes; slave is the controller.
    modport master (
        output wren, din, evt_ack, rd_done,
        input  rb_we, rb_waddr, rb_wdata, evt_avail, evt_base,
               full, n_occ, ovfl_cnt, seq_err
    );

    modport slave (
        input  wren, din, evt_ack, rd_done,
        output rb_we, rb_waddr, rb_wdata, evt_avail, evt_base,
               full, n_occ, ovfl_cnt, seq_err
    );

endinterface

// File: rtl/ringbuf_wr_ctrl.sv
// Writes fixed-size sample events into a slotted ring buffer, announces complete
// events to the readout and tracks slot occupancy, drops and handshake errors.
module ringbuf_wr_ctrl
    import ringbuf_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int SAMPLES = 8
) (
    input logic               clk_i,
    input logic               rst_n_i,
    ringbuf_wr_ctrl_if.slave  bus
);

    localparam int EVT_WORDS = evt_words(SAMPLES);
    localparam int NSLOTS    = nslots(ADDR_W, SAMPLES);
    localparam int OFF_W     = $clog2(EVT_WORDS);
    localparam int SLOT_W    = $clog2(NSLOTS);
    localparam int NOCC_W    = SLOT_W + 1;

    localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(EVT_WORDS - 1);
    localparam logic [OFF_W-1:0]  OFF_ONE   = OFF_W'(1);
    localparam logic [NOCC_W-1:0] NSLOTS_V  = NOCC_W'(NSLOTS);
    localparam logic [NOCC_W-1:0] CNT_ONE   = NOCC_W'(1);

    wr_state_e               state_q,    state_d;
    logic [SLOT_W-1:0]       wr_slot_q,  wr_slot_d;
    logic [OFF_W-1:0]        offset_q,   offset_d;
    logic [SLOT_W-1:0]       ann_ptr_q,  ann_ptr_d;
    logic [NOCC_W-1:0]       n_occ_q,    n_occ_d;
    logic [NOCC_W-1:0]       n_ready_q,  n_ready_d;
    logic [NOCC_W-1:0]       n_acked_q,  n_acked_d;
    logic [7:0]              ovfl_q,     ovfl_d;
    logic                    seq_err_q,  seq_err_d;
    logic                    rb_we_q,    rb_we_d;
    logic [ADDR_W-1:0]       rb_waddr_q, rb_waddr_d;
    logic [SAMPLE_W-1:0]     rb_wdata_q, rb_wdata_d;

    logic                    alloc;
    logic                    mark_ready;
    logic                    ack_ok;
    logic                    free_slot;

    // Write-side FSM: framing is purely by WREN word count.
    always_comb begin
        state_d    = state_q;
        wr_slot_d  = wr_slot_q;
        offset_d   = offset_q;
        ovfl_d     = ovfl_q;
        rb_we_d    = 1'b0;
        rb_waddr_d = rb_waddr_q;
        rb_wdata_d = rb_wdata_q;
        alloc      = 1'b0;
        mark_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.wren) begin
                    offset_d = OFF_ONE;
                    if (n_occ_q < NSLOTS_V) begin
                        alloc      = 1'b1;
                        rb_we_d    = 1'b1;
                        rb_waddr_d = {wr_slot_q, {OFF_W{1'b0}}};
                        rb_wdata_d = bus.din;
                        state_d    = ST_FILL;
                    end else begin
                        if (ovfl_q != 8'hFF) begin
                            ovfl_d = ovfl_q + 8'd1;
                        end
                        state_d = ST_DROP;
                    end
                end
            end

            ST_FILL: begin
                if (bus.wren) begin
                    rb_we_d    = 1'b1;
                    rb_waddr_d = {wr_slot_q, offset_q};
                    rb_wdata_d = bus.din;
                    offset_d   = offset_q + OFF_ONE;
                    if (offset_q == OFF_LAST) begin
                        mark_ready = 1'b1;
                        wr_slot_d  = wr_slot_q + SLOT_W'(1);
                        state_d    = ST_IDLE;
                    end
                end
            end

            ST_DROP: begin
                if (bus.wren) begin
                    offset_d = offset_q + OFF_ONE;
                    if (offset_q == OFF_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Readout handshakes act on registered counts, so a slot freed this cycle
    // only becomes allocatable next cycle.
    always_comb begin
        ack_ok    = bus.evt_ack && (n_ready_q != '0);
        free_slot = bus.rd_done && (n_acked_q != '0);
        ann_ptr_d = ack_ok ? (ann_ptr_q + SLOT_W'(1)) : ann_ptr_q;
        seq_err_d = seq_err_q | (bus.rd_done & (n_acked_q == '0));

        n_ready_d = n_ready_q;
        case ({mark_ready, ack_ok})
            2'b10:   n_ready_d = n_ready_q + CNT_ONE;
            2'b01:   n_ready_d = n_ready_q - CNT_ONE;
            default: n_ready_d = n_ready_q;
        endcase

        n_acked_d = n_acked_q;
        case ({ack_ok, free_slot})
            2'b10:   n_acked_d = n_acked_q + CNT_ONE;
            2'b01:   n_acked_d = n_acked_q - CNT_ONE;
            default: n_acked_d = n_acked_q;
        endcase

        n_occ_d = n_occ_q;
        case ({alloc, free_slot})
            2'b10:   n_occ_d = n_occ_q + CNT_ONE;
            2'b01:   n_occ_d = n_occ_q - CNT_ONE;
            default: n_occ_d = n_occ_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            wr_slot_q  <= '0;
            offset_q   <= '0;
            ann_ptr_q  <= '0;
            n_occ_q    <= '0;
            n_ready_q  <= '0;
            n_acked_q  <= '0;
            ovfl_q     <= '0;
            seq_err_q  <= 1'b0;
            rb_we_q    <= 1'b0;
            rb_waddr_q <= '0;
            rb_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_slot_q  <= wr_slot_d;
            offset_q   <= offset_d;
            ann_ptr_q  <= ann_ptr_d;
            n_occ_q    <= n_occ_d;
            n_ready_q  <= n_ready_d;
            n_acked_q  <= n_acked_d;
            ovfl_q     <= ovfl_d;
            seq_err_q  <= seq_err_d;
            rb_we_q    <= rb_we_d;
            rb_waddr_q <= rb_waddr_d;
            rb_wdata_q <= rb_wdata_d;
        end
    end

    assign bus.rb_we     = rb_we_q;
    assign bus.rb_waddr  = rb_waddr_q;
    assign bus.rb_wdata  = rb_wdata_q;
    assign bus.evt_avail = (n_ready_q != '0);
    assign bus.evt_base  = {ann_ptr_q, {OFF_W{1'b0}}};
    assign bus.full      = (n_occ_q == NSLOTS_V);
    assign bus.n_occ     = n_occ_q;
    assign bus.ovfl_cnt  = ovfl_q;
    assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_ringbuf_wr_ctrl.sv
// Directed, self-checking bench for ringbuf_wr_ctrl: event writes, overflow,
// readout handshakes, reset behaviour and slot wrap.
module tb_ringbuf_wr_ctrl;

    localparam int ADDR_W  = 11;
    localparam int SAMPLES = 8;
    localparam int EW      = 128;
    localparam int NS      = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ringbuf_wr_ctrl_if #(.ADDR_W(ADDR_W), .SAMPLES(SAMPLES)) bus ();

    ringbuf_wr_ctrl #(.ADDR_W(ADDR_W), .SAMPLES(SAMPLES)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic        ack;
        logic        done;
        logic        avail;
        logic [10:0] base;
        logic        full;
        logic [4:0]  nocc;
        logic        seqerr;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wren    = 1'b0;
        bus.din     = '0;
        bus.evt_ack = 1'b0;
        bus.rd_done = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic avail, input logic [10:0] base,
                              input logic full, input logic [4:0] nocc,
                              input logic [7:0] ovfl, input logic seqerr);
        chk({tag, ".evt_avail"}, 32'(bus.evt_avail), 32'(avail));
        chk({tag, ".evt_base"},  32'(bus.evt_base),  32'(base));
        chk({tag, ".full"},      32'(bus.full),      32'(full));
        chk({tag, ".n_occ"},     32'(bus.n_occ),     32'(nocc));
        chk({tag, ".ovfl_cnt"},  32'(bus.ovfl_cnt),  32'(ovfl));
        chk({tag, ".seq_err"},   32'(bus.seq_err),   32'(seqerr));
        $display("status %s: avail=%0b base=%0d full=%0b n_occ=%0d ovfl=%0d seq_err=%0b",
                 tag, bus.evt_avail, bus.evt_base, bus.full, bus.n_occ, bus.ovfl_cnt, bus.seq_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rb_we"},    32'(bus.rb_we),    32'd0);
        chk({tag, ".rb_waddr"}, 32'(bus.rb_waddr), 32'd0);
        chk({tag, ".rb_wdata"}, 32'(bus.rb_wdata), 32'd0);
        chk_status(tag, 1'b0, 11'd0, 1'b0, 5'd0, 8'd0, 1'b0);
    endtask

    // Reset is asserted away from the clock edge and checked before any edge.
    task automatic apply_reset(input string tag);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk_all_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_event(input string tag, input logic [11:0] seed, input logic exp_we,
                              input logic [10:0] exp_base, input bit gaps,
                              input bit done_first, input bit ack_last);
        for (int i = 0; i < EW; i++) begin
            bus.wren    = 1'b1;
            bus.din     = seed + 12'(i);
            bus.rd_done = done_first && (i == 0);
            bus.evt_ack = ack_last && (i == EW - 1);
            step();
            idle_inputs();
            if (exp_we)
                chk({tag, ".word"}, {8'h00, bus.rb_we, bus.rb_waddr, bus.rb_wdata},
                    {8'h00, 1'b1, exp_base + 11'(i), seed + 12'(i)});
            else
                chk({tag, ".nowrite"}, 32'(bus.rb_we), 32'd0);
            if (gaps && (i % 3 == 1)) begin
                step();
                chk({tag, ".gap"}, 32'(bus.rb_we), 32'd0);
            end
        end
        $display("event %s: seed=0x%0h expect_write=%0b base=%0d", tag, seed, exp_we, exp_base);
    endtask

    task automatic fill_all();
        for (int e = 0; e < NS; e++)
            send_event($sformatf("fill%0d", e), 12'(e * 16), 1'b1, 11'(e * EW), (e == 1), 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic ack, input logic done);
        bus.evt_ack = ack;
        bus.rd_done = done;
        step();
        idle_inputs();
    endtask

    initial begin
        int seen_we;

        // Starting from 16 full slots (none acked), readout handshake sequence.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 11'd128, 1'b1, 5'd16, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 11'd256, 1'b1, 5'd16, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 11'd256, 1'b0, 5'd15, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 11'd256, 1'b0, 5'd14, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 11'd256, 1'b0, 5'd14, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 11'd256, 1'b0, 5'd14, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 11'd384, 1'b0, 5'd14, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 11'd384, 1'b0, 5'd13, 1'b1};

        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        chk_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // First event lands in slot 0 and is announced.
        send_event("ev0", 12'h000, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0);
        chk_status("ev0", 1'b1, 11'd0, 1'b0, 5'd1, 8'd0, 1'b0);

        for (int e = 1; e < NS; e++)
            send_event($sformatf("ev%0d", e), 12'(e * 16), 1'b1, 11'(e * EW), (e == 1), 1'b0, 1'b0);
        chk_status("full16", 1'b1, 11'd0, 1'b1, 5'd16, 8'd0, 1'b0);

        send_event("ev16", 12'h555, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0);
        chk_status("drop17", 1'b1, 11'd0, 1'b1, 5'd16, 8'd1, 1'b0);

        // Overflow counter saturation: 254 more drops reach 255, one more holds it.
        seen_we = 0;
        bus.wren = 1'b1;
        for (int c = 0; c < 254 * EW; c++) begin
            step();
            if (bus.rb_we) seen_we++;
        end
        bus.wren = 1'b0;
        step();
        chk("sat.ovfl255", 32'(bus.ovfl_cnt), 32'd255);
        bus.wren = 1'b1;
        for (int c = 0; c < EW; c++) begin
            step();
            if (bus.rb_we) seen_we++;
        end
        idle_inputs();
        step();
        chk("sat.ovfl_hold", 32'(bus.ovfl_cnt), 32'd255);
        chk("sat.no_writes", 32'(seen_we), 32'd0);
        $display("saturation: ovfl=%0d writes=%0d", bus.ovfl_cnt, seen_we);

        for (int v = 0; v < 8; v++) begin
            pulse(tbl[v].ack, tbl[v].done);
            chk_status($sformatf("vec%0d", v), tbl[v].avail, tbl[v].base, tbl[v].full,
                       tbl[v].nocc, 8'd255, tbl[v].seqerr);
        end

        // Release with nothing acknowledged: sticky error, occupancy untouched.
        apply_reset("rst_seq");
        pulse(1'b0, 1'b1);
        chk_status("seqerr", 1'b0, 11'd0, 1'b0, 5'd0, 8'd0, 1'b1);
        repeat (3) step();
        chk("seqerr.sticky", 32'(bus.seq_err), 32'd1);

        // Slot freed in the same cycle as the first word: event still dropped.
        apply_reset("rst_a");
        fill_all();
        pulse(1'b1, 1'b0);
        send_event("same_cycle", 12'h7A0, 1'b0, 11'd0, 1'b0, 1'b1, 1'b0);
        chk_status("same_cycle", 1'b1, 11'd128, 1'b0, 5'd15, 8'd1, 1'b0);

        // Slot freed one cycle earlier: event wraps into slot 0.
        apply_reset("rst_b");
        fill_all();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        chk("early.n_occ", 32'(bus.n_occ), 32'd15);
        send_event("wrap", 12'h3C0, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0);
        chk_status("wrap", 1'b1, 11'd128, 1'b1, 5'd16, 8'd0, 1'b0);

        // Reset mid-event discards the partial event.
        apply_reset("rst_c");
        for (int i = 0; i < 50; i++) begin
            bus.wren = 1'b1;
            bus.din  = 12'hA00 + 12'(i);
            step();
            idle_inputs();
            chk("partial.word", {8'h00, bus.rb_we, bus.rb_waddr, bus.rb_wdata},
                {8'h00, 1'b1, 11'(i), 12'hA00 + 12'(i)});
        end
        chk("partial.avail", 32'(bus.evt_avail), 32'd0);
        apply_reset("rst_mid");
        send_event("after_rst", 12'h100, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0);
        chk_status("after_rst", 1'b1, 11'd0, 1'b0, 5'd1, 8'd0, 1'b0);

        // Ack coincident with ready-mark of the second event.
        send_event("ev_ack_last", 12'h200, 1'b1, 11'd128, 1'b0, 1'b0, 1'b1);
        chk_status("ack_last", 1'b1, 11'd128, 1'b0, 5'd2, 8'd0, 1'b0);
        pulse(1'b1, 1'b0);
        chk_status("ack2", 1'b0, 11'd256, 1'b0, 5'd2, 8'd0, 1'b0);
        pulse(1'b1, 1'b0);
        chk_status("ack_ignored", 1'b0, 11'd256, 1'b0, 5'd2, 8'd0, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        chk_status("drained", 1'b0, 11'd256, 1'b0, 5'd0, 8'd0, 1'b0);
        pulse(1'b0, 1'b1);
        chk("drained.seq_err", 32'(bus.seq_err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ringbuf_wr_ctrl.md
RINGBUF_WR_CTRL -- requirements
Module: ringbuf_wr_ctrl

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the ring buffer depth to 2^ADDR_W 12-bit words.
REQ-002 Parameter SAMPLES, default 8, SHALL set samples per channel per event; EVT_WORDS = 16*SAMPLES (128); NSLOTS = 2^ADDR_W/EVT_WORDS (16).
REQ-003 CLK  input  1  sole clock; all logic on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 WREN  input  1  sample-valid strobe from transfer stage.
REQ-006 DIN  input  12  multiplexed sample (DMUX), valid with WREN.
REQ-007 EVT_ACK  input  1  readout accepts announced event.
REQ-008 RD_DONE  input  1  readout finished the oldest acknowledged event; frees its slot.
REQ-009 RB_WE  output  1  ring buffer write enable.
REQ-010 RB_WADDR  output  ADDR_W  ring buffer write address.
REQ-011 RB_WDATA  output  12  ring buffer write data.
REQ-012 EVT_AVAIL  output  1  at least one complete, unannounced event.
REQ-013 EVT_BASE  output  ADDR_W  base address of the oldest unannounced event, valid while EVT_AVAIL.
REQ-014 FULL  output  1  all NSLOTS slots occupied.
REQ-015 N_OCC  output  log2(NSLOTS)+1  occupied-slot count.
REQ-016 OVFL_CNT  output  8  dropped-event counter, saturating at 255.
REQ-017 SEQ_ERR  output  1  sticky: RD_DONE received with no acknowledged slot outstanding.

Function
REQ-018 Buffer SHALL be divided into NSLOTS slots; slot s covers addresses s*EVT_WORDS .. s*EVT_WORDS+EVT_WORDS-1; slots used strictly in ring order.
REQ-019 FSM states SHALL be IDLE, FILL, DROP.
REQ-020 IDLE + WREN + N_OCC<NSLOTS: allocate slot wr_slot, N_OCC+1, write word offset 0, go to FILL.
REQ-021 IDLE + WREN + FULL: no write, OVFL_CNT+1 (saturating), go to DROP.
REQ-022 FILL: each WREN writes DIN at {wr_slot, offset}, offset+1; on offset EVT_WORDS-1: mark slot ready, wr_slot+1 mod NSLOTS, go to IDLE.
REQ-023 DROP: count WREN words; on the EVT_WORDS-th word go to IDLE; no writes.
REQ-024 RB_WE/RB_WADDR/RB_WDATA SHALL be registered: one-cycle latency from WREN.
REQ-025 Cycles without WREN SHALL not advance the offset; event framing is by word count only.
REQ-026 EVT_AVAIL and EVT_BASE SHALL update the cycle after the last word is written.
REQ-027 EVT_ACK with EVT_AVAIL SHALL advance the announce pointer; EVT_ACK without EVT_AVAIL is ignored.
REQ-028 RD_DONE with at least one acknowledged-unreleased slot SHALL free the oldest one (N_OCC-1); otherwise it is ignored and SEQ_ERR is set.
REQ-029 Simultaneous allocation and RD_DONE SHALL leave N_OCC unchanged; a slot freed in cycle n is allocatable in cycle n+1, not n.
REQ-030 Simultaneous ready-mark and EVT_ACK SHALL both take effect; the ready count stays consistent.
REQ-031 All slot pointers SHALL wrap modulo NSLOTS.

Reset
REQ-032 RST_N low SHALL asynchronously clear: state IDLE, all pointers/counters 0, RB_WE 0, RB_WADDR 0, RB_WDATA 0, EVT_AVAIL 0, EVT_BASE 0, FULL 0, N_OCC 0, OVFL_CNT 0, SEQ_ERR 0.
REQ-033 Reset mid-event SHALL discard the partial event; it is never announced.

Structure
REQ-034 Shared package ringbuf_pkg SHALL hold sample width (12), channel count (16), and the EVT_WORDS/NSLOTS derivation functions.
REQ-035 No sub-module is required; FSM, pointers and counters in one module.

Verification
REQ-036 128 consecutive WREN words 0..127 -> RB_WADDR 0..127, RB_WE lagging one cycle; EVT_AVAIL=1, EVT_BASE=0, N_OCC=1.
REQ-037 17 events, no EVT_ACK/RD_DONE -> FULL after 16th, 17th dropped, OVFL_CNT=1, no RB_WE during 17th, N_OCC=16.
REQ-038 FULL, RD_DONE in the cycle the next event's first WREN arrives -> event dropped, OVFL_CNT+1; RD_DONE one cycle earlier -> event written at slot 0 (wrap), address 0.
REQ-039 RD_DONE with no prior EVT_ACK -> N_OCC unchanged, SEQ_ERR=1 until reset.
REQ-040 RST_N low after 50 words of an event -> all outputs zero; next 128 words written from address 0, EVT_BASE=0.
REQ-041 EVT_ACK coincident with the last word of event 2 while event 1 is pending -> event 1 popped, EVT_BASE=128, EVT_AVAIL stays 1.
